// File: rtl/atm_txn_scheduler_if.sv
// Request/response bus between the ATM front-ends and atm_txn_scheduler.
// Terminals drive the master side; the scheduler owns the slave side.
interface atm_txn_scheduler_if #(
  parameter int N_TERM = 4,
  parameter int IDX_W  = 4,
  parameter int AMT_W  = 11,
  parameter int BAL_W  = 16
);
  logic [N_TERM-1:0]       req;
  logic [2*N_TERM-1:0]     op;
  logic [IDX_W*N_TERM-1:0] src_idx;
  logic [IDX_W*N_TERM-1:0] dst_idx;
  logic [AMT_W*N_TERM-1:0] amount;
  logic [N_TERM-1:0]       grant;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [1:0]              err_code;
  logic [BAL_W-1:0]        bal_out;

  modport master (
    output req, op, src_idx, dst_idx, amount,
    input  grant, busy, done, err, err_code, bal_out
  );

  modport slave (
    input  req, op, src_idx, dst_idx, amount,
    output grant, busy, done, err, err_code, bal_out
  );
endinterface

// File: rtl/atm_txn_scheduler.sv
// Round-robin transaction scheduler owning the single-port ATM balance store.
// Optional per-account daily withdrawal limit enabled by defining ATM_DAILY_LIMIT_EN.
module atm_txn_scheduler #(
  parameter int          N_TERM   = 4,
  parameter int          N_ACC    = 10,
  parameter int          IDX_W    = 4,
  parameter int          AMT_W    = 11,
  parameter int          BAL_W    = 16,
  parameter int unsigned INIT_BAL = 500
`ifdef ATM_DAILY_LIMIT_EN
  ,
  parameter int unsigned DAILY_LIMIT = 1000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef ATM_DAILY_LIMIT_EN
  input  logic               day_clr,
`endif
  atm_txn_scheduler_if.slave bus
);

  localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;

  localparam logic [1:0] OP_BAL  = 2'b00;
  localparam logic [1:0] OP_WD   = 2'b01;
  localparam logic [1:0] OP_DEP  = 2'b10;
  localparam logic [1:0] OP_XFER = 2'b11;

  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_INDEX = 2'b01;
  localparam logic [1:0] EC_FUNDS = 2'b10;
  localparam logic [1:0] EC_LIMIT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SRC,
    S_RD_DST,
    S_EXEC,
    S_WR_SRC,
    S_WR_DST,
    S_RESP
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;

  logic [BAL_W-1:0]  acc_bal [N_ACC];

  // Operands latched at arbitration; terminal-side changes afterwards are ignored.
  logic [1:0]        op_q;
  logic [IDX_W-1:0]  src_q;
  logic [IDX_W-1:0]  dst_q;
  logic [AMT_W-1:0]  amt_q;
  logic [BAL_W-1:0]  src_bal_q;
  logic [BAL_W-1:0]  dst_bal_q;
  logic [BAL_W-1:0]  res_src_q;
  logic [BAL_W-1:0]  res_dst_q;

  logic              arb_hit;
  logic [PTR_W-1:0]  arb_win;
  logic [PTR_W:0]    arb_sum;
  logic [1:0]        sel_op;
  logic [IDX_W-1:0]  sel_src;
  logic [IDX_W-1:0]  sel_dst;
  logic [AMT_W-1:0]  sel_amt;

  logic [BAL_W-1:0]  rd_src;
  logic [BAL_W-1:0]  rd_dst;

  logic              ex_err;
  logic [1:0]        ex_code;
  logic [BAL_W-1:0]  ex_src_new;
  logic [BAL_W-1:0]  ex_dst_new;
  logic [BAL_W:0]    src_sum;
  logic [BAL_W:0]    dst_sum;
  logic              is_wd;
  logic              is_dep;
  logic              is_xfer;
  logic              src_ok;
  logic              dst_ok;

  // Widened add so an overflowing deposit/transfer is detected, never wrapped.
  function automatic logic [BAL_W:0] add_bal(input logic [BAL_W-1:0] bal,
                                             input logic [AMT_W-1:0] amt);
    return {1'b0, bal} + (BAL_W+1)'(amt);
  endfunction

  // First requester at or after the round-robin pointer, wrapping upward.
  always_comb begin
    arb_hit = 1'b0;
    arb_win = '0;
    arb_sum = '0;
    for (int i = 0; i < N_TERM; i++) begin
      arb_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (arb_sum >= (PTR_W+1)'(N_TERM)) arb_sum = arb_sum - (PTR_W+1)'(N_TERM);
      if (!arb_hit && bus.req[arb_sum[PTR_W-1:0]]) begin
        arb_hit = 1'b1;
        arb_win = arb_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_src = '0;
    sel_dst = '0;
    sel_amt = '0;
    for (int i = 0; i < N_TERM; i++) begin
      if (arb_win == PTR_W'(i)) begin
        sel_op  = bus.op[2*i +: 2];
        sel_src = bus.src_idx[IDX_W*i +: IDX_W];
        sel_dst = bus.dst_idx[IDX_W*i +: IDX_W];
        sel_amt = bus.amount[AMT_W*i +: AMT_W];
      end
    end
  end

  always_comb begin
    rd_src = '0;
    rd_dst = '0;
    for (int a = 0; a < N_ACC; a++) begin
      if (src_q == IDX_W'(a)) rd_src = acc_bal[a];
      if (dst_q == IDX_W'(a)) rd_dst = acc_bal[a];
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  logic [BAL_W-1:0] wd_cnt [N_ACC];
  logic [BAL_W-1:0] rd_cnt;
  logic [BAL_W:0]   cnt_sum;

  always_comb begin
    rd_cnt = '0;
    for (int a = 0; a < N_ACC; a++) begin
      if (src_q == IDX_W'(a)) rd_cnt = wd_cnt[a];
    end
    cnt_sum = add_bal(rd_cnt, amt_q);
  end
`endif

  // Checks are prioritised: index, funds, overflow, then daily limit.
  always_comb begin
    is_wd      = (op_q == OP_WD);
    is_dep     = (op_q == OP_DEP);
    is_xfer    = (op_q == OP_XFER);
    src_ok     = (int'(src_q) < N_ACC);
    dst_ok     = (int'(dst_q) < N_ACC);
    src_sum    = add_bal(src_bal_q, amt_q);
    dst_sum    = add_bal(dst_bal_q, amt_q);
    ex_err     = 1'b1;
    ex_code    = EC_NONE;
    ex_src_new = src_bal_q;
    ex_dst_new = dst_sum[BAL_W-1:0];
    if (!src_ok || (is_xfer && (!dst_ok || dst_q == src_q))) begin
      ex_code = EC_INDEX;
    end else if ((is_wd || is_xfer) && (BAL_W'(amt_q) > src_bal_q)) begin
      ex_code = EC_FUNDS;
    end else if ((is_dep && src_sum[BAL_W]) || (is_xfer && dst_sum[BAL_W])) begin
      ex_code = EC_LIMIT;
`ifdef ATM_DAILY_LIMIT_EN
    end else if ((is_wd || is_xfer) && (cnt_sum > (BAL_W+1)'(DAILY_LIMIT))) begin
      ex_code = EC_LIMIT;
`endif
    end else begin
      ex_err = 1'b0;
      if (is_wd || is_xfer) ex_src_new = src_bal_q - BAL_W'(amt_q);
      else if (is_dep)      ex_src_new = src_sum[BAL_W-1:0];
    end
  end

  // Datapath registers: no reset needed, every use is preceded by a load.
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        if (arb_hit) begin
          op_q  <= sel_op;
          src_q <= sel_src;
          dst_q <= sel_dst;
          amt_q <= sel_amt;
        end
      end
      S_RD_SRC: src_bal_q <= rd_src;
      S_RD_DST: dst_bal_q <= rd_dst;
      S_EXEC: begin
        res_src_q <= ex_src_new;
        res_dst_q <= ex_dst_new;
      end
      default: ;
    endcase
  end

  // Balance store: one write per cycle, only from the write states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N_ACC; a++) acc_bal[a] <= BAL_W'(INIT_BAL);
    end else begin
      for (int a = 0; a < N_ACC; a++) begin
        if (state == S_WR_SRC && src_q == IDX_W'(a)) acc_bal[a] <= res_src_q;
        else if (state == S_WR_DST && dst_q == IDX_W'(a)) acc_bal[a] <= res_dst_q;
      end
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N_ACC; a++) wd_cnt[a] <= '0;
    end else if (day_clr) begin
      for (int a = 0; a < N_ACC; a++) wd_cnt[a] <= '0;
    end else begin
      for (int a = 0; a < N_ACC; a++) begin
        if (state == S_WR_SRC && (is_wd || is_xfer) && src_q == IDX_W'(a))
          wd_cnt[a] <= wd_cnt[a] + BAL_W'(amt_q);
      end
    end
  end
`endif

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      bus.grant    <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.err_code <= EC_NONE;
      bus.bal_out  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (arb_hit) begin
            state     <= S_RD_SRC;
            bus.busy  <= 1'b1;
            bus.grant <= {{(N_TERM-1){1'b0}}, 1'b1} << arb_win;
            rr_ptr    <= (arb_win == PTR_W'(N_TERM-1)) ? '0 : arb_win + 1'b1;
          end
        end
        S_RD_SRC: state <= (op_q == OP_XFER) ? S_RD_DST : S_EXEC;
        S_RD_DST: state <= S_EXEC;
        S_EXEC: begin
          if (ex_err || op_q == OP_BAL) begin
            state        <= S_RESP;
            bus.done     <= 1'b1;
            bus.err      <= ex_err;
            bus.err_code <= ex_code;
            bus.bal_out  <= ex_src_new;
          end else begin
            state <= S_WR_SRC;
          end
        end
        S_WR_SRC: begin
          if (op_q == OP_XFER) begin
            state <= S_WR_DST;
          end else begin
            state        <= S_RESP;
            bus.done     <= 1'b1;
            bus.err      <= 1'b0;
            bus.err_code <= EC_NONE;
            bus.bal_out  <= res_src_q;
          end
        end
        S_WR_DST: begin
          state        <= S_RESP;
          bus.done     <= 1'b1;
          bus.err      <= 1'b0;
          bus.err_code <= EC_NONE;
          bus.bal_out  <= res_src_q;
        end
        S_RESP: begin
          state     <= S_IDLE;
          bus.done  <= 1'b0;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
